// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pipe
// Description : RV32 decode stage with register file, WB bypass and ID/EX slot.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic            ex_is_load,
    output logic            ex_mem_we,
    output logic            ex_jump_sel,
    output logic            ex_op1_sel,
    output logic            ex_op2_sel,
    output logic            ex_illegal,
    input  logic            debug_en,
    input  logic [4:0]      debug_addr,
    output logic [XLEN-1:0] debug_data
);

    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LD    = 7'b0000011;
    localparam logic [6:0] c_OP_ST    = 7'b0100011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_R3    = 7'b0110011;
    localparam int         c_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < 6'(NUM_REGS));
    endfunction

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_regs [0:NUM_REGS-1];
    logic [XLEN-1:0] r_ex_pc, r_ex_imm, r_ex_rs1_data, r_ex_rs2_data, r_debug_data;
    logic [31:0]     r_ex_instr;
    logic            r_ex_is_load, r_ex_mem_we, r_ex_jump_sel, r_ex_op1_sel, r_ex_op2_sel, r_ex_illegal;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic            w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_imm_op, w_r3, w_known;
    logic            w_use_rs1, w_use_rs2, w_use_rd, w_bad_idx, w_illegal;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
    logic            w_hazard, w_accept, w_hold;

    assign w_opcode = if_instr[6:0];
    assign w_rs1    = if_instr[19:15];
    assign w_rs2    = if_instr[24:20];
    assign w_rd     = if_instr[11:7];

    assign w_lui    = (w_opcode == c_OP_LUI);
    assign w_auipc  = (w_opcode == c_OP_AUIPC);
    assign w_jal    = (w_opcode == c_OP_JAL);
    assign w_jalr   = (w_opcode == c_OP_JALR);
    assign w_br     = (w_opcode == c_OP_BR);
    assign w_ld     = (w_opcode == c_OP_LD);
    assign w_st     = (w_opcode == c_OP_ST);
    assign w_imm_op = (w_opcode == c_OP_IMM);
    assign w_r3     = (w_opcode == c_OP_R3);
    assign w_known  = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_imm_op | w_r3;

    assign w_use_rs1 = w_jalr | w_br | w_ld | w_st | w_imm_op | w_r3;
    assign w_use_rs2 = w_br | w_st | w_r3;
    assign w_use_rd  = w_known & ~(w_br | w_st);
    // Only fields the format actually uses can make an RV32E instruction illegal
    assign w_bad_idx = (w_use_rs1 & ~in_range(w_rs1)) | (w_use_rs2 & ~in_range(w_rs2)) |
                       (w_use_rd & ~in_range(w_rd));
    assign w_illegal = ~w_known | w_bad_idx;

    always_comb begin
        w_imm32 = '0;
        if (w_jalr | w_ld | w_imm_op)
            w_imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        else if (w_st)
            w_imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        else if (w_br)
            w_imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
        else if (w_lui | w_auipc)
            w_imm32 = {if_instr[31:12], 12'b0};
        else if (w_jal)
            w_imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    end
    assign w_imm = XLEN'($signed(w_imm32));

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rs1 != 5'd0 && in_range(w_rs1)) begin
            w_rs1_data = r_regs[w_rs1[c_IDX_W-1:0]];
            if (BYPASS_EN != 0 && wb_we && wb_rd == w_rs1)
                w_rs1_data = wb_data;
        end
        if (w_rs2 != 5'd0 && in_range(w_rs2)) begin
            w_rs2_data = r_regs[w_rs2[c_IDX_W-1:0]];
            if (BYPASS_EN != 0 && wb_we && wb_rd == w_rs2)
                w_rs2_data = wb_data;
        end
    end

    // Load in EX whose result a source of the offered instruction needs
    assign w_hazard = ex_valid & r_ex_is_load & (ex_rd != 5'd0) &
                      ((w_use_rs1 & (ex_rd == w_rs1)) | (w_use_rs2 & (ex_rd == w_rs2)));
    assign if_ready = (~ex_valid | ex_ready) & ~w_hazard & ~flush;
    assign w_accept = if_valid & if_ready;
    assign w_hold   = ex_valid & ~ex_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (ex_ready && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) w_state_nxt = S_EMPTY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0 && in_range(wb_rd)) begin
            r_regs[wb_rd[c_IDX_W-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_pc       <= '0;
            r_ex_instr    <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_is_load  <= 1'b0;
            r_ex_mem_we   <= 1'b0;
            r_ex_jump_sel <= 1'b0;
            r_ex_op1_sel  <= 1'b0;
            r_ex_op2_sel  <= 1'b0;
            r_ex_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_ex_pc       <= if_pc;
            r_ex_instr    <= if_instr;
            r_ex_imm      <= w_imm;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_rs2_data;
            r_ex_is_load  <= w_ld;
            r_ex_mem_we   <= w_st;
            r_ex_jump_sel <= w_jal | w_jalr;
            r_ex_op1_sel  <= w_auipc | w_jal;
            r_ex_op2_sel  <= w_known & ~w_r3 & ~w_br;
            r_ex_illegal  <= w_illegal;
        end else if (w_hold && wb_we && in_range(wb_rd)) begin
            // Stalled operands track write-back so EX never sees a stale value
            if (wb_rd == ex_rs1 && ex_rs1 != 5'd0) r_ex_rs1_data <= wb_data;
            if (wb_rd == ex_rs2 && ex_rs2 != 5'd0) r_ex_rs2_data <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_debug_data <= '0;
        else if (debug_en && in_range(debug_addr))
            r_debug_data <= r_regs[debug_addr[c_IDX_W-1:0]];
        else
            r_debug_data <= '0;
    end

    assign ex_valid    = (r_state == S_FULL);
    assign ex_pc       = r_ex_pc;
    assign ex_opcode   = r_ex_instr[6:0];
    assign ex_funct3   = r_ex_instr[14:12];
    assign ex_funct7   = r_ex_instr[31:25];
    assign ex_rs1      = r_ex_instr[19:15];
    assign ex_rs2      = r_ex_instr[24:20];
    assign ex_rd       = r_ex_instr[11:7];
    assign ex_imm      = r_ex_imm;
    assign ex_rs1_data = r_ex_rs1_data;
    assign ex_rs2_data = r_ex_rs2_data;
    assign ex_is_load  = r_ex_is_load;
    assign ex_mem_we   = r_ex_mem_we;
    assign ex_jump_sel = r_ex_jump_sel;
    assign ex_op1_sel  = r_ex_op1_sel;
    assign ex_op2_sel  = r_ex_op2_sel;
    assign ex_illegal  = r_ex_illegal;
    assign debug_data  = r_debug_data;

endmodule
`default_nettype wire
